// File: rtl/latent_unpacker_if.sv
// latent_unpacker_if: packed-word input and single-symbol output handshakes of the unpacker.
interface latent_unpacker_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    localparam int CW = $clog2(LANES + 1);
    logic [LANES*WIDTH-1:0] in_data;
    logic [CW-1:0]          in_count;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    modport master (
        output in_data, in_count, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );
    modport slave (
        input  in_data, in_count, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/latent_unpacker.sv
// latent_unpacker: splits packed LANES-symbol words into a WIDTH-bit symbol stream, lane 0 first.
module latent_unpacker #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    latent_unpacker_if.slave  bus,
    output logic              busy,
    output logic              err
);
    localparam int CW = $clog2(LANES + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    logic [0:0]             state_q, state_d;
    logic [LANES*WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]          rem_q, rem_d, count_clamped;
    logic                   last_q, last_d, err_q, err_d;
    logic                   emit, accept, load, shift, done;
    assign emit          = state_q == EMIT;
    assign bus.in_ready  = !emit || (rem_q == CW'(1) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign load          = accept && bus.in_count != '0;
    assign shift         = emit && bus.out_ready && rem_q > CW'(1);
    assign done          = emit && bus.out_ready && rem_q == CW'(1);
    assign count_clamped = bus.in_count > CW'(LANES) ? CW'(LANES) : bus.in_count;
    // Outputs depend only on held state, so reset clears them without a clock edge.
    assign bus.out_valid = emit;
    assign bus.out_data  = emit ? shreg_q[WIDTH-1:0] : '0;
    assign bus.out_last  = emit && last_q && rem_q == CW'(1);
    assign busy          = emit;
    assign err           = err_q;
    always_comb begin
        state_d = load ? EMIT : (accept || done) ? IDLE : state_q;
        shreg_d = load ? bus.in_data : shift ? shreg_q >> WIDTH : shreg_q;
        rem_d   = load ? count_clamped : shift ? rem_q - CW'(1) : (accept || done) ? '0 : rem_q;
        last_d  = load ? bus.in_last : last_q;
        err_d   = accept && bus.in_count == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_latent_unpacker.sv
// tb_latent_unpacker: directed stimulus with a symbol scoreboard filled at word acceptance.
module tb_latent_unpacker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, err;
    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];
    logic exp_err = 1'b0;
    latent_unpacker_if #(.WIDTH(8), .LANES(4)) ifc ();
    latent_unpacker #(.WIDTH(8), .LANES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave), .busy(busy), .err(err));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Called 1ns after a rising edge with inputs already driven for this cycle.
    task automatic cyc();
        logic [8:0] e;
        logic [31:0] n;
        if (ifc.out_valid && ifc.out_ready) begin
            if (sb.size() == 0) chk("extra_symbol", {23'd0, ifc.out_last, ifc.out_data}, 32'h1ff);
            else begin
                e = sb.pop_front();
                chk("symbol", {23'd0, ifc.out_last, ifc.out_data}, {23'd0, e});
            end
        end
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("busy", {31'd0, busy}, {31'd0, ifc.out_valid});
        exp_err = ifc.in_valid && ifc.in_ready && ifc.in_count == 3'd0;
        if (ifc.in_valid && ifc.in_ready) begin
            n = ifc.in_count > 3'd4 ? 4 : 32'(ifc.in_count);
            for (int i = 0; i < n; i++) begin
                e[7:0] = ifc.in_data[i*8 +: 8];
                e[8] = ifc.in_last && i == n - 1;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [31:0] d, input logic [2:0] c, input logic l);
        logic acc;
        int n = 0;
        ifc.in_data = d;
        ifc.in_count = c;
        ifc.in_last = l;
        ifc.in_valid = 1'b1;
        do begin
            acc = ifc.in_ready;
            cyc();
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        ifc.in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        chk("drain_left", sb.size(), 32'd0);
        cyc();
        cyc();
    endtask
    initial begin
        ifc.in_data = '0;
        ifc.in_count = '0;
        ifc.in_last = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, ifc.out_data}, 32'd0);
        chk("rst_out_last", {31'd0, ifc.out_last}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        // single full word with in_ready rising only on the last symbol
        send(32'h44332211, 3'd4, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk("full_in_ready", {31'd0, ifc.in_ready}, {31'd0, i == 4});
            chk("full_valid", {31'd0, ifc.out_valid}, 32'd1);
            cyc();
        end
        chk("full_idle_busy", {31'd0, busy}, 32'd0);
        chk("full_idle_data", {24'd0, ifc.out_data}, 32'd0);
        drain();
        // back-to-back words, no bubble
        send(32'h04030201, 3'd4, 1'b0);
        send(32'h08070605, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid", {31'd0, ifc.out_valid}, 32'd1);
            cyc();
        end
        drain();
        // partial word and clamp
        send(32'hDDCCBBAA, 3'd2, 1'b1);
        drain();
        send(32'hDDCCBBAA, 3'd7, 1'b1);
        drain();
        // backpressure on 0x22
        send(32'h44332211, 3'd4, 1'b1);
        cyc();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_data", {24'd0, ifc.out_data}, 32'h22);
            chk("bp_valid", {31'd0, ifc.out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
            cyc();
        end
        ifc.out_ready = 1'b1;
        drain();
        // zero-count word: dropped, one-cycle err
        chk("zero_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        send(32'hFFFFFFFF, 3'd0, 1'b1);
        chk("zero_err_high", {31'd0, err}, 32'd1);
        chk("zero_no_valid", {31'd0, ifc.out_valid}, 32'd0);
        cyc();
        chk("zero_err_low", {31'd0, err}, 32'd0);
        chk("zero_idle", {31'd0, ifc.in_ready}, 32'd1);
        cyc();
        // asynchronous reset after 0x11 is taken
        send(32'h44332211, 3'd4, 1'b1);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("arst_data", {24'd0, ifc.out_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        exp_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        cyc();
        send(32'h0000AA55, 3'd2, 1'b0);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/latent_unpacker.md
Name: latent_unpacker

Overview:
- Stream width converter from packed bus words to single symbols; the read/decode end of the latent symbol packing path.
- Accepts words of LANES symbols, WIDTH bits each, lane 0 in the LSBs, with a valid/ready handshake.
- Emits one WIDTH-bit symbol per cycle, lane 0 first, with valid/ready and an end-of-frame marker.
- Sits between the bitstream/bus side and the WIDTH-bit symbol datapath blocks.

Parameters:
- WIDTH, 8: bits per symbol.
- LANES, 4: symbols per packed input word; must be at least 2.
- CW, $clog2(LANES+1): width of the in_count field; localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  LANES*WIDTH  packed word; lane k occupies bits [k*WIDTH +: WIDTH].
- in_count  input  CW  number of valid lanes in the word, starting at lane 0.
- in_last  input  1  word is the final word of a frame.
- in_valid  input  1  input word present.
- in_ready  output  1  unpacker can take a word this cycle.
- out_data  output  WIDTH  current symbol.
- out_last  output  1  current symbol is the last symbol of the frame.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream takes the symbol this cycle.
- busy  output  1  high while the unpacker is in EMIT.
- err  output  1  one-cycle pulse when a word with in_count==0 is accepted.

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously to clk by the upstream reset logic. Forces the following values:
  - State IDLE, shift register 0, remaining 0, last_word 0.
  - out_valid 0, out_data 0, out_last 0, busy 0, err 0.
  - in_ready 1 once reset is released.
- Reset during EMIT discards the held word and any untaken symbols; no partial output appears after release.
- States:
  - IDLE: no word held.
  - EMIT: a word is held with remaining ≥ 1.
- Word acceptance: a word is accepted when in_valid && in_ready at a rising edge.
- in_ready is combinational: in_ready = IDLE || (EMIT && remaining==1 && out_ready).
  - in_ready depends on out_ready in the same cycle.
  - There is no in_valid → in_ready path.
- On acceptance with in_count ≥ 1:
  - Load the shift register with in_data.
  - remaining = min(in_count, LANES); values above LANES are clamped.
  - last_word = in_last.
  - Next state EMIT.
- On acceptance with in_count == 0:
  - The word is dropped and produces no output.
  - err pulses high for the next cycle.
  - Next state IDLE.
- EMIT outputs:
  - out_valid = 1.
  - out_data = shreg[WIDTH-1:0].
  - out_last = last_word && remaining==1.
  - busy = 1.
- Symbol transfer: on out_valid && out_ready:
  - If remaining > 1: shreg shifts right by WIDTH bits (zero fill) and remaining decrements.
  - If remaining == 1 and a word is accepted in the same cycle: the new word loads as above, with no bubble between words.
  - If remaining == 1 and no word is accepted: next state IDLE.
- Backpressure: while out_ready is low in EMIT, out_data, out_last and out_valid hold stable and in_ready is 0.
- Latency: first symbol is valid on the cycle after word acceptance.
- Throughput: one symbol per cycle with continuous out_ready and back-to-back input words.
- out_data and out_last are registered or derived only from state (no input→output combinational path). out_data reads 0 in IDLE.
- Frame boundaries require no special handling. in_last only marks out_last; a new frame's word may follow immediately.

Test Plan (WIDTH=8, LANES=4):
- Single full word:
  - Stimulus: reset, then in_data=0x44332211, in_count=4, in_last=1, out_ready held high.
  - Required: out_valid on cycles 1–4 after acceptance with out_data 0x11, 0x22, 0x33, 0x44; out_last only with 0x44; in_ready=0 on cycles 1–3 and in_ready=1 (combinational) on cycle 4; then IDLE, busy=0.
- Back-to-back words:
  - Stimulus: word A=0x04030201 (count 4, last 0) followed by B=0x08070605 (count 4, last 1), in_valid continuous, out_ready high.
  - Required: out_data 01..08 on 8 consecutive cycles with no bubble; B accepted on the cycle 0x04 is taken; out_last only on 0x08.
- Partial word and clamp:
  - Stimulus: in_count=2 with data 0xDDCCBBAA, last 1.
  - Required: only 0xAA then 0xBB, with out_last on 0xBB.
  - Stimulus: in_count=7.
  - Required: exactly 4 symbols.
- Backpressure:
  - Stimulus: word 0x44332211; out_ready low for 3 cycles while 0x22 is presented.
  - Required: out_data holds 0x22 and out_valid stays 1 throughout; in_ready=0; sequence completes 0x11, 0x22, 0x33, 0x44 with none lost or duplicated.
- Zero-count word:
  - Stimulus: in_count=0, in_valid=1 in IDLE.
  - Required: accepted (in_ready=1); err=1 for exactly one cycle; out_valid stays 0; state IDLE.
- Reset mid-word:
  - Stimulus: assert rst_n=0 asynchronously after 0x11 is taken.
  - Required: out_valid, out_data and busy go 0 immediately, without waiting for a clock edge. After release, in_ready=1 and no 0x22/0x33/0x44 ever appears; the next word 0x0000AA55 (count 2) yields 0x55, 0xAA.
